avalon_ram_agent: RTL and testbench

AVALON_RAM_AGENT -- requirements
Module: avalon_ram_agent

---
 rtl/avalon_ram_agent_if.sv | 21 ++
 rtl/avalon_ram_agent.sv | 77 +++++++
 tb/tb_avalon_ram_agent.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/avalon_ram_agent_if.sv
// rtl/avalon_ram_agent_if.sv - Avalon-MM read/write bus between a host and the RAM agent
interface AvalonMmRw;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] host_to_agent;
  logic [31:0] agent_to_host;
  logic        waitrequest;
  logic        readdatavalid;

  modport Agent (
    input  address, byteenable, read, write, host_to_agent,
    output agent_to_host, waitrequest, readdatavalid
  );

  modport Host (
    output address, byteenable, read, write, host_to_agent,
    input  agent_to_host, waitrequest, readdatavalid
  );
endinterface

// File: rtl/avalon_ram_agent.sv
// rtl/avalon_ram_agent.sv - word RAM behind an Avalon-MM agent with fixed-latency pipelined reads
// Defining RAM_AGENT_WRITE_WAIT_EN inserts one wait state ahead of every write.
module avalon_ram_agent #(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic     clk,
  input  logic     reset,
  AvalonMmRw.Agent bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]             mem_q [DEPTH];
  logic [AW-1:0]           idx;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [31:0]             rd_dat_q [READ_LATENCY];
  logic [31:0]             rd_dat_d [READ_LATENCY];
  logic                    rsp_vld;
  logic                    unused_addr;

  assign idx         = bus.address[AW+1:2];
  assign unused_addr = ^{bus.address[31:AW+2], bus.address[1:0]};

  // A read never shares a cycle with a write; the write always wins.
  assign rd_acc = !reset && bus.read && !bus.write;

`ifdef RAM_AGENT_WRITE_WAIT_EN
  logic wr_armed_q, wr_armed_d;

  always_comb begin
    wr_armed_d = bus.write && !wr_armed_q;
  end

  always_ff @(posedge clk) begin
    if (reset) wr_armed_q <= 1'b0;
    else       wr_armed_q <= wr_armed_d;
  end

  assign wr_acc          = !reset && bus.write && wr_armed_q;
  assign bus.waitrequest = reset || (bus.write && (bus.read || !wr_armed_q));
`else
  assign wr_acc          = !reset && bus.write;
  assign bus.waitrequest = reset || (bus.read && bus.write);
`endif

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) mem_q[idx][8*i +: 8] <= bus.host_to_agent[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_vld_d    = '0;
    rd_dat_d    = '{default: 32'h0};
    rd_vld_d[0] = rd_acc;
    rd_dat_d[0] = mem_q[idx];
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_dat_d[i] = rd_dat_q[i-1];
    end
  end

  // Only the valid bits are reset; that alone drops every in-flight read.
  always_ff @(posedge clk) begin
    if (reset) rd_vld_q <= '0;
    else       rd_vld_q <= rd_vld_d;
    rd_dat_q <= rd_dat_d;
  end

  assign rsp_vld           = !reset && rd_vld_q[READ_LATENCY-1];
  assign bus.readdatavalid = rsp_vld;
  assign bus.agent_to_host = rsp_vld ? rd_dat_q[READ_LATENCY-1] : 32'h0;
endmodule

// File: tb/tb_avalon_ram_agent.sv
// tb/tb_avalon_ram_agent.sv - randomized bench for avalon_ram_agent against a behavioural RAM model
// Honours RAM_AGENT_WRITE_WAIT_EN when the design is built with it.
module tb_avalon_ram_agent;
  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  typedef struct { int due; logic [31:0] data; } resp_t;
  typedef struct { int cyc; logic [31:0] data; } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  AvalonMmRw bus ();

  avalon_ram_agent #(.DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] mdl_mem [DEPTH];
  resp_t       pend[$];
  obs_t        got[$];
  bit          wr_waited = 1'b0;
  bit          last_wr_ok, last_rd_ok;
  logic        last_wait;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic set_bus(bit rd, bit wr, logic [31:0] addr, logic [31:0] data, logic [3:0] be);
    bus.read = rd; bus.write = wr; bus.address = addr;
    bus.host_to_agent = data; bus.byteenable = be;
  endtask

  // One bus cycle: compare DUT outputs with the model, then advance the model.
  task automatic tick();
    logic        ew, ev;
    logic [31:0] ed;
    int          widx;
    obs_t        o;
    @(negedge clk);
`ifdef RAM_AGENT_WRITE_WAIT_EN
    ew = rst || (bus.write && (bus.read || !wr_waited));
`else
    ew = rst || (bus.read && bus.write);
`endif
    ev = 1'b0; ed = 32'h0;
    if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
      ev = 1'b1; ed = pend[0].data;
    end
    last_wait = bus.waitrequest;
    check("waitrequest", {31'h0, bus.waitrequest}, {31'h0, ew});
    check("readdatavalid", {31'h0, bus.readdatavalid}, {31'h0, ev});
    check("agent_to_host", bus.agent_to_host, ed);
    if (bus.readdatavalid === 1'b1) begin
      o.cyc = cyc; o.data = bus.agent_to_host; got.push_back(o);
    end
`ifdef RAM_AGENT_WRITE_WAIT_EN
    last_wr_ok = !rst && bus.write && wr_waited;
`else
    last_wr_ok = !rst && bus.write;
`endif
    last_rd_ok = !rst && bus.read && !bus.write;
    widx = int'((bus.address >> 2) % DEPTH);
    if (last_rd_ok) pend.push_back('{cyc + LAT, mdl_mem[widx]});
    if (last_wr_ok)
      for (int b = 0; b < 4; b++)
        if (bus.byteenable[b]) mdl_mem[widx][8*b +: 8] = bus.host_to_agent[8*b +: 8];
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    if (rst) pend.delete();
    wr_waited = !rst && bus.write && !last_wr_ok;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_write(logic [31:0] addr, logic [31:0] data, logic [3:0] be);
    set_bus(1'b0, 1'b1, addr, data, be);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (last_wr_ok) break;
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic do_read(logic [31:0] addr, output int acc);
    acc = -1;
    set_bus(1'b1, 1'b0, addr, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (last_rd_ok) begin acc = cyc - 1; break; end
    end
    set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic idle(int n);
    set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (n) tick();
  endtask

  function automatic logic [31:0] got_data(int k);
    return (got.size() > k) ? got[k].data : 32'hxxxx_xxxx;
  endfunction

  function automatic int got_cyc(int k);
    return (got.size() > k) ? got[k].cyc : -1;
  endfunction

  initial begin
    int a0, acc;
    logic [31:0] addr;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
    set_bus(1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) do_write(i * 4, 32'hC0DE_0000 + i * 32'h0101, 4'hF);

    // Full-word write then immediate read.
    got.delete();
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h10, a0);
    idle(LAT + 2);
    check("rd_after_wr_count", got.size(), 1);
    check("rd_after_wr_data", got_data(0), 32'hDEAD_BEEF);
    check("rd_after_wr_latency", got_cyc(0), a0 + LAT);

    // Partial byte enables.
    got.delete();
    do_write(32'h10, 32'h1122_3344, 4'b0101);
    do_write(32'h10, 32'hFFFF_FFFF, 4'b0000);
    do_read(32'h10, acc);
    idle(LAT + 2);
    check("byteenable_merge", got_data(0), 32'hDE22_BE44);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) do_write(i * 4, i + 1, 4'hF);
    got.delete();
    do_read(32'h0, a0);
    for (int i = 1; i < 4; i++) do_read(i * 4, acc);
    idle(LAT + 2);
    for (int i = 0; i < 4; i++) begin
      check("burst_data", got_data(i), i + 1);
      check("burst_cycle", got_cyc(i), a0 + LAT + i);
    end

    // Read and write together: write first, then the read sees it.
    got.delete();
    set_bus(1'b1, 1'b1, 32'h20, 32'h55, 4'hF);
    tick();
    check("both_high_wait", {31'h0, last_wait}, 32'h1);
    for (int k = 0; k < 6; k++) begin
      if (last_wr_ok) bus.write = 1'b0;
      if (last_rd_ok) break;
      tick();
    end
    idle(LAT + 2);
    check("both_high_data", got_data(0), 32'h55);

    // Address alias past the top of the array.
    got.delete();
    do_write(32'h8, 32'hA5A5_0008, 4'hF);
    do_read(DEPTH * 4 + 32'h8, acc);
    idle(LAT + 2);
    check("alias_data", got_data(0), 32'hA5A5_0008);

    // Reset kills the in-flight read but not the memory.
    got.delete();
    do_read(32'h8, acc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(LAT + 2);
    check("reset_drop_count", got.size(), 0);
    do_read(32'h8, acc);
    idle(LAT + 2);
    check("mem_kept_data", got_data(0), 32'hA5A5_0008);

    // Random traffic, including occasional resets.
    for (int n = 0; n < 3000; n++) begin
      addr = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      rst = ($urandom_range(0, 99) == 0);
      set_bus(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), addr, $urandom,
              4'($urandom_range(0, 15)));
      tick();
    end
    rst = 1'b0;
    idle(LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
